jt12_pcm_feeder: RTL
====================

# jt12_pcm_feeder

Sample-streaming front end that drives the DAC write port of the FM/PCM core (`pcm`/`pcm_wr`) on behalf of the host. It buffers unsigned 8-bit samples pushed by the host in a small FIFO. It also issues one DAC write every `rate_div+1` output-sample periods, paced by the FM sampler's `zero` strobe. This makes the DAC stream jitter-free regardless of host latency, and the downstream upsampler sees evenly spaced writes.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 4 to 64.
- `PRIME`, 4: FIFO level required before streaming starts; 1 to `DEPTH`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `clk_en` in 1: clock enable; all state advances only when high.
- `enable` in 1: stream enable; low flushes the FIFO and returns the block to IDLE.
- `zero` in 1: output-sample strobe level from the FM sampler, held for ≥2 `clk_en` cycles.
- `rate_div` in 4: a write is issued every `rate_div+1` rising edges of `zero`.
- `din` in 8: unsigned host sample.
- `din_valid` in 1: host sample valid.
- `din_ready` out 1: the FIFO accepts a sample.
- `underrun_clr` in 1: clears `underrun`.
- `pcm` out 9 signed: DAC word to the core.
- `pcm_wr` out 1: DAC write strobe.
- `underrun` out 1: sticky flag; a tick found the FIFO empty.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Edge detect: `last_zero` is registered on `clk_en`. A zero edge is `zero && !last_zero`.
- Divider: `div_cnt` (4 bits) increments on each zero edge. When `div_cnt == rate_div` on a zero edge, it reloads 0 and raises an internal `tick`. If `rate_div` changes mid-count and `div_cnt > rate_div`, the counter wraps at 15 and then resumes normally.
- Push: a sample is stored on any `clk_en` cycle with `din_valid && din_ready`. `din_ready = enable && (level != DEPTH)`, decoded from the registered `level`.
- Conversion: `pcm = {~d[7], d[6:0], 1'b0}`, where `d` is the popped sample. For example, 0x80→0, 0xFF→+254, 0x00→−256.
- States:
  - IDLE: FIFO held empty; `div_cnt` is 0. Exit to PRIME when `enable` is high.
  - PRIME: the FIFO fills and ticks are ignored. Exit to RUN when `level >= PRIME`.
  - RUN: each tick pops one sample, loads `pcm`, and pulses `pcm_wr`. A tick with the FIFO empty sets `underrun` (see Configuration). RUN does not return to PRIME.
  - Any state goes to IDLE when `enable` is low; the FIFO is flushed and `div_cnt` is cleared. `pcm` keeps its value.
- Simultaneous push and pop: `level` is unchanged. On an empty FIFO, the pop is evaluated first and is an underrun; the pushed sample is stored.
- `underrun`: set has priority over `underrun_clr` in the same cycle.

## Timing
- Reset values: `pcm`=0, `pcm_wr`=0, `underrun`=0, `level`=0, `din_ready`=0, state IDLE, `div_cnt`=0, `last_zero`=0.
- Write latency: the zero edge is registered at `clk_en` cycle N. `tick` is combinational in cycle N. `pcm` and `pcm_wr` are registered high during cycle N+1.
- `pcm_wr` is high for exactly one `clk_en` period. `pcm` is stable from the start of that period until the next write.
- Push to `level` latency: 1 `clk_en` cycle.
- A push into an empty FIFO in RUN is poppable by the tick in the next `clk_en` cycle.

## Configuration
- Macro `JT12_PCM_FEEDER_HOLD_EN`.
- Defined: on an underrun tick, no `pcm_wr` is issued and `pcm` keeps its last value. The DAC holds, which avoids clicks.
- Undefined: on an underrun tick, `pcm` is loaded with 0 (midscale) and `pcm_wr` pulses normally.
- `underrun` is set in both builds.

## Structure
- Package `jt12_pcm_pkg` holds:
  - the state enum (IDLE, PRIME, RUN);
  - the `PCM_MID` constant, 9'sd0;
  - a `u8_to_pcm` conversion function.
- Sub-module `jt12_pcm_fifo`: synchronous FIFO with push, pop, flush, `level`, full and empty; registered read pointer, first-word-fall-through data.
- Divider, edge detect, FSM and output registers live in the top level.

## Test plan
- Reset mid-RUN with 5 samples queued → the next cycle shows `level`=0, `pcm`=0, `pcm_wr`=0, state IDLE.
- `rate_div`=2, push 0x80, 0xFF, 0x00, 0x40 with `PRIME`=4, 9 zero edges → exactly 3 `pcm_wr` pulses, on edges 3, 6 and 9. `pcm` = 0, +254, −256.
- Push 20 samples with `DEPTH`=16 and no zero edges → `din_ready` drops at `level`=16. Only 16 samples are accepted.
- In RUN, with 1 queued sample and `rate_div`=0, apply 2 zero edges → one write, then `underrun`=1. The HOLD build has no second pulse. The non-HOLD build pulses a second time with `pcm`=0.
- Apply the underrun tick and `underrun_clr` in the same cycle → `underrun` stays 1. `underrun_clr` alone in a later cycle → 0.
- Drop `enable` with 7 queued → `level`=0 and `din_ready`=0 the next cycle. Re-enable → PRIME, and no write occurs until `level` ≥ 4.

Source files
------------

// File: rtl/jt12_pcm_pkg.sv
// Shared definitions for the PCM sample feeder.
//   state_t    : feeder sequencing states (IDLE, PRIME, RUN)
//   PCM_MID    : DAC midscale word
//   u8_to_pcm  : unsigned 8-bit host sample -> signed 9-bit DAC word
package jt12_pcm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic signed [8:0] PCM_MID = 9'sd0;

    // Flipping the MSB turns offset-binary into two's complement; the
    // extra LSB scales the 8-bit sample to the 9-bit DAC range.
    function automatic logic signed [8:0] u8_to_pcm(input logic [7:0] d);
        return {~d[7], d[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/jt12_pcm_fifo.sv
// Synchronous sample FIFO with first-word-fall-through output.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : empties the FIFO (priority over push/pop)
//   push, din     : write strobe and data (ignored when full)
//   pop           : advance the read pointer (ignored when empty)
//   dout          : word at the head of the FIFO, valid when !empty
//   level         : occupancy, 0..DEPTH
//   full, empty   : decoded from the registered level
module jt12_pcm_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;

    logic do_push;
    logic do_pop;

    assign full    = (level_reg == LW'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign level   = level_reg;

    // Head word is read straight from the array so a sample written in
    // one cycle is visible at the output in the next.
    assign dout = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/jt12_pcm_feeder.sv
// PCM sample feeder: buffers host samples and writes them to the DAC port
// once every rate_div+1 rising edges of the FM sampler's zero strobe.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clk_en         : clock enable for all state
//   enable         : stream enable; low flushes and returns to IDLE
//   zero           : output-sample strobe level
//   rate_div       : write every rate_div+1 zero edges
//   din, din_valid : host sample and its valid
//   din_ready      : FIFO can accept a sample
//   underrun_clr   : clears the sticky underrun flag
//   pcm, pcm_wr    : DAC word and one-clk_en-period write strobe
//   underrun       : sticky, set when a write tick finds the FIFO empty
//   level          : FIFO occupancy
// Build option: JT12_PCM_FEEDER_HOLD_EN - when defined an underrun tick
// issues no write (DAC holds); otherwise midscale is written.
module jt12_pcm_feeder
    import jt12_pcm_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PRIME = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_en,
    input  logic                       enable,
    input  logic                       zero,
    input  logic [3:0]                 rate_div,
    input  logic [7:0]                 din,
    input  logic                       din_valid,
    output logic                       din_ready,
    input  logic                       underrun_clr,
    output logic signed [8:0]          pcm,
    output logic                       pcm_wr,
    output logic                       underrun,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int LW = $clog2(DEPTH) + 1;

    state_t state_reg;
    state_t state_next;

    logic                last_zero_reg;
    logic [3:0]          div_cnt_reg;
    logic signed [8:0]   pcm_reg;
    logic                pcm_wr_reg;
    logic                underrun_reg;

    logic          zero_edge;
    logic          tick;
    logic          run_tick;
    logic          underrun_set;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic [7:0]    fifo_dout;
    logic [LW-1:0] fifo_level;
    logic          fifo_full;
    logic          fifo_empty;

    assign zero_edge    = zero && !last_zero_reg;
    // Equality compare: if rate_div drops below the running count, the
    // counter runs on to 15, wraps, and then matches normally.
    assign tick         = zero_edge && (div_cnt_reg == rate_div);
    assign run_tick     = enable && (state_reg == ST_RUN) && tick;
    assign underrun_set = run_tick && fifo_empty;

    assign din_ready  = enable && !fifo_full;
    assign fifo_push  = clk_en && din_valid && din_ready;
    // An empty-FIFO tick is an underrun even if a push lands in the same
    // cycle; that sample is stored and served by a later tick.
    assign fifo_pop   = clk_en && run_tick && !fifo_empty;
    assign fifo_flush = clk_en && !enable;

    jt12_pcm_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .din   (din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else if (clk_en) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  state_next = ST_PRIME;
                ST_PRIME: if (fifo_level >= LW'(PRIME)) state_next = ST_RUN;
                ST_RUN:   state_next = ST_RUN;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_zero_reg <= 1'b0;
            div_cnt_reg   <= 4'd0;
            pcm_reg       <= PCM_MID;
            pcm_wr_reg    <= 1'b0;
            underrun_reg  <= 1'b0;
        end else if (clk_en) begin
            last_zero_reg <= zero;
            pcm_wr_reg    <= 1'b0;

            if (!enable || state_reg == ST_IDLE) begin
                div_cnt_reg <= 4'd0;
            end else if (zero_edge) begin
                div_cnt_reg <= tick ? 4'd0 : div_cnt_reg + 4'd1;
            end

            if (run_tick) begin
                if (!fifo_empty) begin
                    pcm_reg    <= u8_to_pcm(fifo_dout);
                    pcm_wr_reg <= 1'b1;
                end else begin
`ifdef JT12_PCM_FEEDER_HOLD_EN
                    pcm_reg    <= pcm_reg;
`else
                    pcm_reg    <= PCM_MID;
                    pcm_wr_reg <= 1'b1;
`endif
                end
            end

            if (underrun_set) begin
                underrun_reg <= 1'b1;
            end else if (underrun_clr) begin
                underrun_reg <= 1'b0;
            end
        end
    end

    assign pcm      = pcm_reg;
    assign pcm_wr   = pcm_wr_reg;
    assign underrun = underrun_reg;
    assign level    = fifo_level;

endmodule
